// File: rtl/instr_loader_pkg.sv
// Shared state encoding and default widths for the front-panel instruction loader.
package instr_loader_pkg;

   localparam int DEF_ADDR_W = 5;
   localparam int DEF_DATA_W = 16;

   typedef enum logic [2:0] {
      IDLE,
      COLLECT,
      WRITE,
      VERIFY,
      DONE
   } loader_state_t;

endpackage

// File: rtl/instr_loader_if.sv
// Bundle between the panel synchronizers, the loader and the instruction-memory write port.
// Mem_Rd_Data only exists when INSTR_LOADER_VERIFY_EN is defined.
interface instr_loader_if #(
   parameter int ADDR_W = instr_loader_pkg::DEF_ADDR_W,
   parameter int DATA_W = instr_loader_pkg::DEF_DATA_W
);

   logic              Load_Mode;
   logic              Enter;
   logic              Finish;
   logic [3:0]        Nibble_In;
   logic [ADDR_W-1:0] Mem_Addr;
   logic [DATA_W-1:0] Mem_Data;
   logic              Mem_Wr;
   logic              Proc_Hold;
   logic [1:0]        Nib_Idx;
   logic              Done;
   logic              Err;
`ifdef INSTR_LOADER_VERIFY_EN
   logic [DATA_W-1:0] Mem_Rd_Data;

   modport master (
      output Load_Mode, Enter, Finish, Nibble_In, Mem_Rd_Data,
      input  Mem_Addr, Mem_Data, Mem_Wr, Proc_Hold, Nib_Idx, Done, Err
   );

   modport slave (
      input  Load_Mode, Enter, Finish, Nibble_In, Mem_Rd_Data,
      output Mem_Addr, Mem_Data, Mem_Wr, Proc_Hold, Nib_Idx, Done, Err
   );
`else
   modport master (
      output Load_Mode, Enter, Finish, Nibble_In,
      input  Mem_Addr, Mem_Data, Mem_Wr, Proc_Hold, Nib_Idx, Done, Err
   );

   modport slave (
      input  Load_Mode, Enter, Finish, Nibble_In,
      output Mem_Addr, Mem_Data, Mem_Wr, Proc_Hold, Nib_Idx, Done, Err
   );
`endif

endinterface

// File: rtl/instr_loader_rise_detect.sv
// One-bit registered rising-edge detector; a held level yields a single-cycle pulse.
module rise_detect (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic rise
);

   logic prev_q;
   logic prev_d;

   always_comb begin
      prev_d = din;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prev_q <= 1'b0;
      end else begin
         prev_q <= prev_d;
      end
   end

   assign rise = din & ~prev_q;

endmodule

// File: rtl/instr_loader.sv
// Front-panel program writer: assembles hex nibbles into words and writes them to instruction memory.
// Define INSTR_LOADER_VERIFY_EN to add a read-back check after every write (drives Err).
module instr_loader #(
   parameter int ADDR_W = instr_loader_pkg::DEF_ADDR_W,
   parameter int DATA_W = instr_loader_pkg::DEF_DATA_W
) (
   input logic           CLOCK_50,
   input logic           Reset,
   instr_loader_if.slave bus
);

   import instr_loader_pkg::*;

   localparam int                NIBBLES  = DATA_W / 4;
   localparam logic [1:0]        LAST_NIB = 2'(NIBBLES - 1);
   localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

   loader_state_t     state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [1:0]        nib_idx_q, nib_idx_d;
   logic              mem_wr_q, mem_wr_d;
   logic              proc_hold_q, proc_hold_d;
   logic              done_q, done_d;
   logic              advance;
   logic              enter_evt;
   logic              finish_evt;
`ifdef INSTR_LOADER_VERIFY_EN
   logic              err_q, err_d;
`endif

   rise_detect u_enter_rise (
      .clk  (CLOCK_50),
      .rst  (Reset),
      .din  (bus.Enter),
      .rise (enter_evt)
   );

   rise_detect u_finish_rise (
      .clk  (CLOCK_50),
      .rst  (Reset),
      .din  (bus.Finish),
      .rise (finish_evt)
   );

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      data_d      = data_q;
      nib_idx_d   = nib_idx_q;
      mem_wr_d    = 1'b0;
      proc_hold_d = proc_hold_q;
      done_d      = done_q;
      advance     = 1'b0;
`ifdef INSTR_LOADER_VERIFY_EN
      err_d       = err_q;
`endif

      unique case (state_q)
         IDLE: begin
            proc_hold_d = 1'b0;
            if (bus.Load_Mode) begin
               state_d     = COLLECT;
               addr_d      = '0;
               data_d      = '0;
               nib_idx_d   = '0;
               done_d      = 1'b0;
               proc_hold_d = 1'b1;
`ifdef INSTR_LOADER_VERIFY_EN
               err_d       = 1'b0;
`endif
            end
         end

         // Abort beats Finish beats Enter; a partial word is simply dropped.
         COLLECT: begin
            if (!bus.Load_Mode) begin
               state_d     = IDLE;
               proc_hold_d = 1'b0;
            end else if (finish_evt) begin
               state_d   = DONE;
               done_d    = 1'b1;
               data_d    = '0;
               nib_idx_d = '0;
            end else if (enter_evt) begin
               data_d    = {data_q[DATA_W-5:0], bus.Nibble_In};
               nib_idx_d = nib_idx_q + 2'd1;
               if (nib_idx_q == LAST_NIB) begin
                  state_d  = WRITE;
                  mem_wr_d = 1'b1;
               end
            end
         end

         WRITE: begin
`ifdef INSTR_LOADER_VERIFY_EN
            state_d = VERIFY;
`else
            advance = 1'b1;
`endif
         end

`ifdef INSTR_LOADER_VERIFY_EN
         // Address and data are still held here, so the read port shows the word just written.
         VERIFY: begin
            if (bus.Mem_Rd_Data != data_q) begin
               err_d = 1'b1;
            end
            advance = 1'b1;
         end
`endif

         DONE: begin
            done_d = 1'b1;
            if (!bus.Load_Mode) begin
               state_d     = IDLE;
               proc_hold_d = 1'b0;
            end else begin
               proc_hold_d = 1'b1;
            end
         end

         default: begin
            state_d     = IDLE;
            proc_hold_d = 1'b0;
         end
      endcase

      // Last address ends the load rather than wrapping back over word 0.
      if (advance) begin
         data_d    = '0;
         nib_idx_d = '0;
         if (addr_q == ADDR_MAX) begin
            state_d = DONE;
            done_d  = 1'b1;
         end else begin
            state_d = COLLECT;
            addr_d  = addr_q + ADDR_W'(1);
         end
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (Reset) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         data_q      <= '0;
         nib_idx_q   <= '0;
         mem_wr_q    <= 1'b0;
         proc_hold_q <= 1'b0;
         done_q      <= 1'b0;
`ifdef INSTR_LOADER_VERIFY_EN
         err_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         data_q      <= data_d;
         nib_idx_q   <= nib_idx_d;
         mem_wr_q    <= mem_wr_d;
         proc_hold_q <= proc_hold_d;
         done_q      <= done_d;
`ifdef INSTR_LOADER_VERIFY_EN
         err_q       <= err_d;
`endif
      end
   end

   assign bus.Mem_Addr  = addr_q;
   assign bus.Mem_Data  = data_q;
   assign bus.Mem_Wr    = mem_wr_q;
   assign bus.Proc_Hold = proc_hold_q;
   assign bus.Nib_Idx   = nib_idx_q;
   assign bus.Done      = done_q;
`ifdef INSTR_LOADER_VERIFY_EN
   assign bus.Err       = err_q;
`else
   assign bus.Err       = 1'b0;
`endif

endmodule

// File: tb/tb_instr_loader.sv
// Directed self-checking bench for instr_loader; the read-back scenario runs when INSTR_LOADER_VERIFY_EN is defined.
module tb_instr_loader;

   logic CLOCK_50 = 1'b0;
   logic Reset;

   int checkCount = 0;
   int passCount  = 0;

   logic [4:0]  wrAddrLog[$];
   logic [15:0] wrDataLog[$];

   instr_loader_if bus ();

   instr_loader dut (
      .CLOCK_50 (CLOCK_50),
      .Reset    (Reset),
      .bus      (bus)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   // Every write strobe seen on the falling edge is logged for later comparison.
   always @(negedge CLOCK_50) begin
      if (bus.Mem_Wr === 1'b1) begin
         wrAddrLog.push_back(bus.Mem_Addr);
         wrDataLog.push_back(bus.Mem_Data);
      end
   end

`ifdef INSTR_LOADER_VERIFY_EN
   logic [15:0] stubMem [32];
   logic        corruptRead = 1'b0;

   always @(posedge CLOCK_50) begin
      if (bus.Mem_Wr === 1'b1) begin
         stubMem[bus.Mem_Addr] <= bus.Mem_Data;
      end
   end

   assign bus.Mem_Rd_Data = corruptRead ? 16'h0000 : stubMem[bus.Mem_Addr];
`endif

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end else begin
         passCount++;
      end
   endtask

   // Drive one cycle of panel inputs; returns 1 time unit after the consuming edge.
   task automatic applyStimulus(input logic enterIn, input logic finishIn, input logic [3:0] nib);
      bus.Enter     = enterIn;
      bus.Finish    = finishIn;
      bus.Nibble_In = nib;
      @(posedge CLOCK_50);
      #1;
   endtask

   task automatic pressNibble(input logic [3:0] nib);
      applyStimulus(1'b1, 1'b0, nib);
      applyStimulus(1'b0, 1'b0, nib);
   endtask

   // Four presses, then one settle cycle so the word has fully retired in either build.
   task automatic loadWord(input logic [15:0] w);
      for (int i = 3; i >= 0; i--) begin
         pressNibble(w[i*4 +: 4]);
      end
      applyStimulus(1'b0, 1'b0, 4'h0);
   endtask

   task automatic checkResetValues(input string prefix);
      checkOutput({prefix, " Mem_Addr"},  32'(bus.Mem_Addr),  32'h0);
      checkOutput({prefix, " Mem_Data"},  32'(bus.Mem_Data),  32'h0);
      checkOutput({prefix, " Mem_Wr"},    32'(bus.Mem_Wr),    32'h0);
      checkOutput({prefix, " Proc_Hold"}, 32'(bus.Proc_Hold), 32'h0);
      checkOutput({prefix, " Nib_Idx"},   32'(bus.Nib_Idx),   32'h0);
      checkOutput({prefix, " Done"},      32'(bus.Done),      32'h0);
      checkOutput({prefix, " Err"},       32'(bus.Err),       32'h0);
   endtask

   initial begin
      Reset         = 1'b1;
      bus.Load_Mode = 1'b0;
      bus.Enter     = 1'b0;
      bus.Finish    = 1'b0;
      bus.Nibble_In = 4'h0;
      applyStimulus(1'b0, 1'b0, 4'h0);
      applyStimulus(1'b0, 1'b0, 4'h0);
      checkResetValues("por");

      // Test 1: one full word 1234 at address 0.
      Reset         = 1'b0;
      bus.Load_Mode = 1'b1;
      applyStimulus(1'b0, 1'b0, 4'h0);
      checkOutput("t1 hold on entry", 32'(bus.Proc_Hold), 32'h1);
      pressNibble(4'h1);
      checkOutput("t1 nib idx 1", 32'(bus.Nib_Idx), 32'h1);
      checkOutput("t1 data 0001", 32'(bus.Mem_Data), 32'h0001);
      pressNibble(4'h2);
      pressNibble(4'h3);
      applyStimulus(1'b1, 1'b0, 4'h4);
      checkOutput("t1 wr strobe", 32'(bus.Mem_Wr), 32'h1);
      checkOutput("t1 wr addr", 32'(bus.Mem_Addr), 32'h0);
      checkOutput("t1 wr data", 32'(bus.Mem_Data), 32'h1234);
      applyStimulus(1'b0, 1'b0, 4'h4);
      applyStimulus(1'b0, 1'b0, 4'h0);
      checkOutput("t1 next addr", 32'(bus.Mem_Addr), 32'h1);
      checkOutput("t1 nib cleared", 32'(bus.Nib_Idx), 32'h0);
      checkOutput("t1 data cleared", 32'(bus.Mem_Data), 32'h0);
      checkOutput("t1 hold kept", 32'(bus.Proc_Hold), 32'h1);
      checkOutput("t1 wr count", 32'(wrAddrLog.size()), 32'd1);
      if (wrDataLog.size() > 0) begin
         checkOutput("t1 logged data", 32'(wrDataLog[0]), 32'h1234);
      end

      // Test 2: a held Enter counts once.
      repeat (10) applyStimulus(1'b1, 1'b0, 4'hA);
      applyStimulus(1'b0, 1'b0, 4'hA);
      checkOutput("t2 nib idx", 32'(bus.Nib_Idx), 32'h1);
      checkOutput("t2 data", 32'(bus.Mem_Data), 32'h000A);

      // Test 3: partial word then Finish (together with Enter) discards it.
      pressNibble(4'hB);
      checkOutput("t3 data 00AB", 32'(bus.Mem_Data), 32'h00AB);
      checkOutput("t3 nib idx 2", 32'(bus.Nib_Idx), 32'h2);
      applyStimulus(1'b1, 1'b1, 4'hC);
      checkOutput("t3 done", 32'(bus.Done), 32'h1);
      checkOutput("t3 hold in done", 32'(bus.Proc_Hold), 32'h1);
      checkOutput("t3 no strobe", 32'(bus.Mem_Wr), 32'h0);
      applyStimulus(1'b0, 1'b0, 4'h0);
      pressNibble(4'hD);
      checkOutput("t3 enter ignored in done", 32'(bus.Nib_Idx), 32'h0);
      checkOutput("t3 wr count", 32'(wrAddrLog.size()), 32'd1);
      bus.Load_Mode = 1'b0;
      applyStimulus(1'b0, 1'b0, 4'h0);
      checkOutput("t3 hold released", 32'(bus.Proc_Hold), 32'h0);
      checkOutput("t3 done sticky", 32'(bus.Done), 32'h1);
      applyStimulus(1'b0, 1'b0, 4'h0);
      checkOutput("t3 idle hold", 32'(bus.Proc_Hold), 32'h0);

      // Test 4: fill all 32 words with data equal to address.
      wrAddrLog.delete();
      wrDataLog.delete();
      bus.Load_Mode = 1'b1;
      applyStimulus(1'b0, 1'b0, 4'h0);
      checkOutput("t4 done cleared", 32'(bus.Done), 32'h0);
      checkOutput("t4 start addr", 32'(bus.Mem_Addr), 32'h0);
      for (int w = 0; w < 32; w++) begin
         loadWord(16'(w));
      end
      checkOutput("t4 wr count", 32'(wrAddrLog.size()), 32'd32);
      for (int i = 0; i < wrAddrLog.size(); i++) begin
         checkOutput("t4 wr addr", 32'(wrAddrLog[i]), 32'(i));
         checkOutput("t4 wr data", 32'(wrDataLog[i]), 32'(i));
      end
      checkOutput("t4 done", 32'(bus.Done), 32'h1);
      checkOutput("t4 no wrap", 32'(bus.Mem_Addr), 32'd31);
      checkOutput("t4 hold", 32'(bus.Proc_Hold), 32'h1);
      checkOutput("t4 no err", 32'(bus.Err), 32'h0);
      pressNibble(4'hF);
      checkOutput("t4 no extra write", 32'(wrAddrLog.size()), 32'd32);
      bus.Load_Mode = 1'b0;
      applyStimulus(1'b0, 1'b0, 4'h0);

      // Test 5: reset in the middle of the second word.
      bus.Load_Mode = 1'b1;
      applyStimulus(1'b0, 1'b0, 4'h0);
      loadWord(16'h5A5A);
      checkOutput("t5 addr after word", 32'(bus.Mem_Addr), 32'h1);
      pressNibble(4'h6);
      pressNibble(4'h7);
      checkOutput("t5 partial data", 32'(bus.Mem_Data), 32'h0067);
      Reset = 1'b1;
      applyStimulus(1'b0, 1'b0, 4'h0);
      checkResetValues("t5 reset");
      checkOutput("t5 wr count", 32'(wrAddrLog.size()), 32'd33);
      Reset = 1'b0;
      applyStimulus(1'b0, 1'b0, 4'h0);
      checkOutput("t5 reload hold", 32'(bus.Proc_Hold), 32'h1);
      checkOutput("t5 reload addr", 32'(bus.Mem_Addr), 32'h0);

      // Dropping Load_Mode mid-word aborts without writing and keeps the address.
      loadWord(16'hC0DE);
      pressNibble(4'h9);
      bus.Load_Mode = 1'b0;
      applyStimulus(1'b0, 1'b0, 4'h0);
      checkOutput("abort hold", 32'(bus.Proc_Hold), 32'h0);
      checkOutput("abort addr kept", 32'(bus.Mem_Addr), 32'h1);
      checkOutput("abort not done", 32'(bus.Done), 32'h0);
      checkOutput("abort wr count", 32'(wrAddrLog.size()), 32'd34);

`ifdef INSTR_LOADER_VERIFY_EN
      // Test 6: memory reads back zero for BEEF.
      bus.Load_Mode = 1'b1;
      applyStimulus(1'b0, 1'b0, 4'h0);
      corruptRead = 1'b1;
      loadWord(16'hBEEF);
      corruptRead = 1'b0;
      checkOutput("t6 err set", 32'(bus.Err), 32'h1);
      checkOutput("t6 continues", 32'(bus.Mem_Addr), 32'h1);
      loadWord(16'h1111);
      checkOutput("t6 err sticky", 32'(bus.Err), 32'h1);
      checkOutput("t6 next addr", 32'(bus.Mem_Addr), 32'h2);
      bus.Load_Mode = 1'b0;
      applyStimulus(1'b0, 1'b0, 4'h0);
      bus.Load_Mode = 1'b1;
      applyStimulus(1'b0, 1'b0, 4'h0);
      checkOutput("t6 err cleared", 32'(bus.Err), 32'h0);
`endif

      $display("[TB] %0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/instr_loader.md
Name: instr_loader

Overview:
- Front-panel program writer for the 16-bit processor.
- Collects an instruction word one hex nibble at a time from switches, then writes it into instruction memory at an auto-incrementing address.
- Holds the processor in reset while loading.
- Sits between the button/switch synchronizers and the instruction-memory write port, opposite the hex-display monitor path that reads IR/PC/ALU state back out.

Parameters:
ADDR_W, 5, instruction-memory address width (matches 5-bit PC)
DATA_W, 16, instruction width; must be a multiple of 4
NIBBLES, DATA_W/4, nibbles per word (derived, localparam)

Ports:
CLOCK_50  input  1  system clock
Reset  input  1  synchronous, active-high reset
Load_Mode  input  1  level; 1 = loader owns memory and processor is held; 0 = run
Enter  input  1  synchronized button level; rising edge accepts Nibble_In
Finish  input  1  synchronized button level; rising edge ends loading early
Nibble_In  input  4  hex digit from switches
Mem_Addr  output  ADDR_W  write address
Mem_Data  output  DATA_W  write data (assembled word)
Mem_Wr  output  1  one-cycle write strobe
Proc_Hold  output  1  drives processor reset while loading
Nib_Idx  output  2  count of nibbles already entered for the current word (for HEX display)
Done  output  1  program load complete
Err  output  1  sticky error flag (see Optional Feature)

Behaviour:
- Reset values: Mem_Addr=0, Mem_Data=0, Mem_Wr=0, Proc_Hold=0, Nib_Idx=0, Done=0, Err=0, state=IDLE, edge-detect registers=0.
- Edge detect: registered copies of Enter and Finish; an event is `cur & ~prev`. Holding a button generates exactly one event.
- States: IDLE, COLLECT, WRITE, DONE.
- IDLE:
  - Proc_Hold=0.
  - Load_Mode=1 -> COLLECT next cycle, with Mem_Addr=0, Nib_Idx=0, Done=0, Err=0.
- COLLECT:
  - Proc_Hold=1.
  - Enter event: Mem_Data <= {Mem_Data[DATA_W-5:0], Nibble_In}, so the first nibble ends up most significant. Nib_Idx increments.
  - When the last nibble (Nib_Idx==NIBBLES-1) is accepted -> WRITE.
- WRITE:
  - Exactly one cycle; Mem_Wr=1 with Mem_Addr and Mem_Data stable.
  - Next cycle: Nib_Idx=0, Mem_Data=0.
  - If Mem_Addr == 2^ADDR_W-1 -> DONE, with no address wrap.
  - Otherwise Mem_Addr+1 and return to COLLECT.
- Finish event in COLLECT:
  - A partial word (Nib_Idx≠0) is discarded and not written.
  - Go to DONE.
- DONE:
  - Done=1; Proc_Hold stays 1 while Load_Mode=1.
  - Load_Mode=0 -> IDLE; Proc_Hold drops, Done stays 1 until the next load begins.
- Load_Mode=0 during COLLECT: abort to IDLE. No write; Mem_Addr is retained for display only.
- Enter and Finish events in the same cycle: Finish wins.
- Events arriving in WRITE are ignored; the edge is consumed.
- Reset mid-load: immediate return to reset values. No Mem_Wr is issued in the reset cycle.
- Mem_Wr is never asserted outside WRITE.

Optional Feature:
Macro INSTR_LOADER_VERIFY_EN.
- Defined:
  - Adds input Mem_Rd_Data[DATA_W-1:0], read combinationally at Mem_Addr.
  - Adds a state VERIFY after WRITE, lasting 1 cycle, which compares Mem_Rd_Data with Mem_Data.
  - Mismatch sets Err=1 (sticky until the next load begins); loading continues.
  - Per-word latency becomes 2 cycles after the last Enter.
- Undefined: no port, no VERIFY state, Err tied to 0.

Decomposition:
- Package instr_loader_pkg holds:
  - `typedef enum logic [2:0] {IDLE, COLLECT, WRITE, VERIFY, DONE} loader_state_t`
  - default ADDR_W/DATA_W constants.
- One natural sub-module: rise_detect, a 1-bit registered rising-edge detector, instantiated for Enter and Finish.

Test Plan:
1. Reset, Load_Mode=1, enter nibbles 1,2,3,4 -> one Mem_Wr pulse with Mem_Addr=0 and Mem_Data=16'h1234; then Mem_Addr=1, Nib_Idx=0, Proc_Hold=1.
2. Hold Enter high for 10 cycles with Nibble_In=A -> exactly one nibble accepted (Nib_Idx=1).
3. Enter A,B, then Finish -> no Mem_Wr; Done=1. Load_Mode=0 -> Proc_Hold=0, state IDLE.
4. Load 32 words (data = address) -> 32 Mem_Wr pulses at addresses 0..31, then DONE with Mem_Addr=31 and no wrap to 0.
5. Assert Reset after 2 nibbles of the second word -> all outputs return to reset values in the following cycle; Mem_Wr stays 0.
6. With INSTR_LOADER_VERIFY_EN, stub memory returns 16'h0000 for a write of 16'hBEEF -> Err=1 after the VERIFY cycle; loading continues to the next address.
